// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared constants, arbiter state encoding and
// one-hot/index helpers for the 16-port crossbar.
package crossbar_pkg;

    localparam int CROSSBAR_PORTS = 16;
    localparam int CROSSBAR_ID_W  = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } arb_state_e;

    // Port index -> one-hot port vector.
    function automatic logic [CROSSBAR_PORTS-1:0] idx2onehot(input logic [CROSSBAR_ID_W-1:0] idx);
        return CROSSBAR_PORTS'(1) << idx;
    endfunction

    // One-hot port vector -> port index (zero vector maps to 0).
    function automatic logic [CROSSBAR_ID_W-1:0] onehot2idx(input logic [CROSSBAR_PORTS-1:0] oh);
        logic [CROSSBAR_ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < CROSSBAR_PORTS; i++) begin
            if (oh[i]) idx = idx | CROSSBAR_ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/crossbar_rr_pick.sv
// crossbar_rr_pick: combinational round-robin pick. Rotates the request
// vector so the pointer lands on bit 0, priority-encodes the lowest set
// bit, then rotates the result back into absolute port numbering.
module crossbar_rr_pick
    import crossbar_pkg::*;
(
    input  logic [CROSSBAR_PORTS-1:0] i_req,
    input  logic [CROSSBAR_ID_W-1:0]  i_ptr,
    output logic                      o_found,
    output logic [CROSSBAR_ID_W-1:0]  o_idx,
    output logic [CROSSBAR_PORTS-1:0] o_onehot
);

    logic [CROSSBAR_PORTS-1:0] w_rot;
    logic [CROSSBAR_ID_W-1:0]  w_off;

    // Rotate, find the first requester at or above the pointer, map back.
    always_comb begin
        w_rot    = (i_req >> i_ptr) | (i_req << (5'd16 - {1'b0, i_ptr}));
        w_off    = '0;
        for (int i = CROSSBAR_PORTS-1; i >= 0; i--) begin
            if (w_rot[i]) w_off = CROSSBAR_ID_W'(i);
        end
        o_found  = |i_req;
        o_idx    = i_ptr + w_off;
        o_onehot = o_found ? idx2onehot(o_idx) : '0;
    end

endmodule

// File: rtl/crossbar_arbiter.sv
// crossbar_arbiter: round-robin ownership arbiter for the 16-port crossbar.
// One owner at a time; ownership is held until the owner drops its request,
// then the pointer moves past it. Every output is registered.
// Optional feature macro CROSSBAR_ARB_TIMEOUT_EN: bounds ownership to
// MAX_HOLD cycles, pulses timeout on a forced release and blocks the
// revoked port until it drops its request.
module crossbar_arbiter
    import crossbar_pkg::*;
#(
    parameter int NUM_PORTS = CROSSBAR_PORTS,
    parameter int MAX_HOLD  = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_PORTS-1:0]     request,
    output logic [NUM_PORTS-1:0]     grant,
    output logic [CROSSBAR_ID_W-1:0] owner,
    output logic                     busy,
    output logic                     set_owner,
    output logic                     clr_owner,
    output logic                     timeout
);

    if (NUM_PORTS != CROSSBAR_PORTS) begin : g_bad_ports
        $error("crossbar_arbiter supports exactly 16 ports");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("crossbar_arbiter MAX_HOLD must be at least 2");
    end

    arb_state_e               r_state, w_state_nxt;
    logic [NUM_PORTS-1:0]     r_grant, w_grant_nxt;
    logic [CROSSBAR_ID_W-1:0] r_owner, w_owner_nxt;
    logic [CROSSBAR_ID_W-1:0] r_ptr,   w_ptr_nxt;
    logic                     r_busy,  w_busy_nxt;
    logic                     r_set,   w_set_nxt;
    logic                     r_clr,   w_clr_nxt;

    logic [NUM_PORTS-1:0]     w_mask;
    logic [NUM_PORTS-1:0]     w_elig;
    logic                     w_found;
    logic [CROSSBAR_ID_W-1:0] w_pick_idx;
    logic [NUM_PORTS-1:0]     w_pick_oh;
    logic                     w_expire;

`ifdef CROSSBAR_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0]    r_hold;
    logic [NUM_PORTS-1:0] r_mask;
    logic                 r_timeout;

    // A voluntary drop wins over expiry, so expiry requires the request high.
    assign w_expire = (r_state == S_BUSY) && request[r_owner] &&
                      (r_hold == HOLD_W'(MAX_HOLD - 1));
    assign w_mask   = r_mask;
    assign timeout  = r_timeout;

    // Hold counter (zero while idle), block mask and timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold    <= '0;
            r_mask    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_hold    <= (r_state == S_BUSY && !w_expire) ? r_hold + 1'b1 : '0;
            r_mask    <= (r_mask & request) | ({NUM_PORTS{w_expire}} & r_grant);
            r_timeout <= w_expire;
        end
    end
`else
    assign w_expire = 1'b0;
    assign w_mask   = '0;
    assign timeout  = 1'b0;
`endif

    assign w_elig = request & ~w_mask;

    crossbar_rr_pick u_pick (
        .i_req    (w_elig),
        .i_ptr    (r_ptr),
        .o_found  (w_found),
        .o_idx    (w_pick_idx),
        .o_onehot (w_pick_oh)
    );

    // Next-state and registered-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_busy_nxt  = r_busy;
        w_set_nxt   = 1'b0;
        w_clr_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_BUSY;
                    w_grant_nxt = w_pick_oh;
                    w_owner_nxt = w_pick_idx;
                    w_busy_nxt  = 1'b1;
                    w_set_nxt   = 1'b1;
                end
            end
            S_BUSY: begin
                if (!request[r_owner] || w_expire) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_owner_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_clr_nxt   = 1'b1;
                    w_ptr_nxt   = r_owner + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_set   <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= w_busy_nxt;
            r_set   <= w_set_nxt;
            r_clr   <= w_clr_nxt;
        end
    end

    assign grant     = r_grant;
    assign owner     = r_owner;
    assign busy      = r_busy;
    assign set_owner = r_set;
    assign clr_owner = r_clr;

endmodule

// File: tb/tb_crossbar_arbiter.sv
// tb_crossbar_arbiter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against an ownership model.
module tb_crossbar_arbiter;

    localparam int MAXH = 4;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] request = 16'h0;
    logic [15:0] grant;
    logic [3:0]  owner;
    logic        busy, set_owner, clr_owner, timeout;

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    crossbar_arbiter #(.NUM_PORTS(16), .MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .request   (request),
        .grant     (grant),
        .owner     (owner),
        .busy      (busy),
        .set_owner (set_owner),
        .clr_owner (clr_owner),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // ---------------- ownership model ----------------
    // m_own: current owner or -1; m_held: grant cycles seen so far.
    int          m_own  = -1;
    int          m_ptr  = 0;
    int          m_held = 0;
    logic [15:0] m_mask = 16'h0;
    logic        m_set = 1'b0, m_clr = 1'b0, m_to = 1'b0;

    function automatic int rr_find(input logic [15:0] elig, input int ptr);
        for (int k = 0; k < 16; k++) begin
            if (elig[(ptr + k) % 16]) return (ptr + k) % 16;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own <= -1; m_ptr <= 0; m_held <= 0; m_mask <= 16'h0;
            m_set <= 1'b0; m_clr <= 1'b0; m_to <= 1'b0;
        end else begin
            m_set <= 1'b0; m_clr <= 1'b0; m_to <= 1'b0;
            m_mask <= m_mask & request;
            if (m_own < 0) begin
                if (rr_find(request & ~m_mask, m_ptr) >= 0) begin
                    m_own  <= rr_find(request & ~m_mask, m_ptr);
                    m_held <= 1;
                    m_set  <= 1'b1;
                end
            end else if (!request[m_own]) begin
                m_own <= -1; m_ptr <= (m_own + 1) % 16; m_clr <= 1'b1;
            end else if (TO_EN && m_held >= MAXH) begin
                m_own <= -1; m_ptr <= (m_own + 1) % 16; m_clr <= 1'b1; m_to <= 1'b1;
                m_mask <= (m_mask & request) | (16'h1 << m_own);
            end else begin
                m_held <= m_held + 1;
            end
        end
    end

    logic [15:0] e_grant;
    logic [3:0]  e_owner;
    assign e_grant = (m_own < 0) ? 16'h0 : (16'h1 << m_own);
    assign e_owner = (m_own < 0) ? 4'h0 : 4'(m_own);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_grant",   32'(grant),     32'(e_grant));
            chk("cyc_owner",   32'(owner),     32'(e_owner));
            chk("cyc_busy",    32'(busy),      32'(m_own >= 0));
            chk("cyc_set",     32'(set_owner), 32'(m_set));
            chk("cyc_clr",     32'(clr_owner), 32'(m_clr));
            chk("cyc_timeout", 32'(timeout),   32'(m_to));
            chk("cyc_set_clr_excl", 32'(set_owner & clr_owner), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        request = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog time limit expired");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        int p;
        do_reset();
        cmp_en = 1'b1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);

        // Single requester: grant one cycle after request, release one after drop.
        request = 16'h0001;
        tick();
        chk("t1_grant", 32'(grant), 32'h0001);
        chk("t1_set",   32'(set_owner), 32'h1);
        chk("t1_owner", 32'(owner), 32'h0);
        chk("t1_model_grant", 32'(e_grant), 32'h0001);
        tick();
        chk("t1_set_once", 32'(set_owner), 32'h0);
        tick(); tick();
        request = 16'h0000;
        tick();
        chk("t1_clr",      32'(clr_owner), 32'h1);
        chk("t1_grant_off", 32'(grant), 32'h0);
        chk("t1_model_clr", 32'(m_clr), 32'h1);

        // Owner 3 drops while 7 rises: release, then 7 one cycle later.
        request = 16'h0008;
        tick();
        chk("t37_grant3", 32'(grant), 32'h0008);
        request = 16'h0080;
        tick();
        chk("t37_release", 32'(grant), 32'h0);
        chk("t37_clr", 32'(clr_owner), 32'h1);
        tick();
        chk("t37_grant7", 32'(grant), 32'h0080);
        chk("t37_owner7", 32'(owner), 32'h7);
        request = 16'h0;
        tick(); tick();

        // Ports 0 and 15 alternate with an idle cycle between owners.
        do_reset();
        request = 16'h8001;
        tick();
        for (int i = 0; i < 4; i++) begin
            p = (i % 2 == 0) ? 0 : 15;
            chk("alt_grant", 32'(grant), 32'(16'h1 << p));
            tick(); tick();
            request[p] = 1'b0;
            tick();
            chk("alt_gap", 32'(grant), 32'h0);
            request[p] = 1'b1;
            tick();
        end

        // All 16 requesting, one-cycle ownership: strict rotation.
        do_reset();
        request = 16'hFFFF;
        tick();
        for (int i = 0; i < 17; i++) begin
            p = i % 16;
            chk("rot_grant", 32'(grant), 32'(16'h1 << p));
            request[p] = 1'b0;
            tick();
            chk("rot_gap", 32'(grant), 32'h0);
            request[p] = 1'b1;
            tick();
        end

        // Asynchronous reset mid-grant.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_clr",   32'(clr_owner), 32'h0);
        chk("arst_busy",  32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_regrant0", 32'(grant), 32'h0001);

`ifdef CROSSBAR_ARB_TIMEOUT_EN
        // Port 2 held alongside port 5 is revoked after 4 grant cycles.
        do_reset();
        request = 16'h0024;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_hold", 32'(grant), 32'h0004);
            tick();
        end
        chk("to_pulse", 32'(timeout), 32'h1);
        chk("to_grant_off", 32'(grant), 32'h0);
        chk("to_clr", 32'(clr_owner), 32'h1);
        tick();
        chk("to_grant5", 32'(grant), 32'h0020);
        request = 16'h0004;
        tick(); tick(); tick();
        chk("to_blocked", 32'(grant), 32'h0);
        request = 16'h0000;
        tick();
        request = 16'h0004;
        tick();
        chk("to_unblocked", 32'(grant), 32'h0004);
`endif

        // Randomized level requests.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int q = 0; q < 16; q++) begin
                if (request[q]) begin
                    if ($urandom_range(0, 5) == 0) request[q] = 1'b0;
                end else begin
                    if ($urandom_range(0, 4) == 0) request[q] = 1'b1;
                end
            end
            if ($urandom_range(0, 199) == 0) request = 16'hFFFF;
            tick();
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
